// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, returning
// read data / write acks in issue order, tagged with the requester id.
module dpram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      ram_valid,
  input  logic                      ram_ready,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  input  logic [DATA_W-1:0]         ram_q,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_we,
  output logic [DATA_W-1:0]         resp_q
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] buf_id, buf_id_inc;
  logic [ID_W-1:0] arb_ptr, grant_id;
  logic            grant_any, handshake, can_accept, load;

  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_we;
  logic [ID_W-1:0]       pipe_id [RD_LATENCY];

  // Modular add that wraps by compare, so non-power-of-two NUM_REQ works.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  assign ram_valid  = (state == ISSUE);
  assign handshake  = ram_valid && ram_ready;
  assign buf_id_inc = wrap_add(buf_id, 1);
  // A handshake frees the buffer this cycle, so arbitration already sees the advanced pointer.
  assign arb_ptr    = handshake ? buf_id_inc : ptr;
  assign can_accept = !rst && ((state == IDLE) || handshake);

  // First requesting slot at or after arb_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!grant_any && req_valid[wrap_add(arb_ptr, off)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_add(arb_ptr, off);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    req_ready = '0;
    load      = 1'b0;
    if (handshake) begin
      ptr_nxt   = buf_id_inc;
      state_nxt = IDLE;
    end
    if (can_accept && grant_any) begin
      req_ready[grant_id] = 1'b1;
      load                = 1'b1;
      state_nxt           = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Issue buffer drives the RAM port directly; held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      buf_id   <= '0;
    end else if (load) begin
      ram_we   <= req_we[grant_id];
      ram_addr <= req_addr[grant_id*ADDR_W +: ADDR_W];
      ram_data <= req_data[grant_id*DATA_W +: DATA_W];
      buf_id   <= grant_id;
    end
  end

  // Latency pipe: the last stage lines up with ram_q for the matching read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_we    <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_valid[0] <= handshake;
      pipe_we[0]    <= ram_we;
      pipe_id[0]    <= buf_id;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_we[i]    <= pipe_we[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign resp_valid = pipe_valid[RD_LATENCY-1];
  assign resp_id    = resp_valid ? pipe_id[RD_LATENCY-1] : '0;
  assign resp_we    = resp_valid && pipe_we[RD_LATENCY-1];
  assign resp_q     = (resp_valid && !resp_we) ? ram_q : '0;

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one dpram port (port A or port B instance) between NUM_REQ requesters.
- Round-robin arbitration over the requester valid/ready channels; the granted request is held in a registered issue buffer and presented to the RAM port valid/ready handshake.
- Read data, and an acknowledge for each write, are returned to the originating requester on a shared response bus tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, cycles from RAM handshake (ram_valid && ram_ready) to ram_q valid (1..4).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_we  in  NUM_REQ  per-requester write enable.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice i.
- req_data  in  NUM_REQ*DATA_W  packed write data.
- ram_valid  out  1  request to RAM port.
- ram_ready  in  1  RAM port accept.
- ram_we  out  1  to RAM port we.
- ram_addr  out  ADDR_W  to RAM port addr.
- ram_data  out  DATA_W  to RAM port data.
- ram_q  in  DATA_W  RAM read data.
- resp_valid  out  1  response strobe, one cycle.
- resp_id  out  $clog2(NUM_REQ)  originating requester.
- resp_we  out  1  1 = write ack, 0 = read data.
- resp_q  out  DATA_W  read data; 0 for write acks.

Behaviour:
- Reset: rst is sampled on posedge clk. On reset:
  - req_ready, ram_valid, ram_we, ram_addr, ram_data, resp_valid, resp_id, resp_we and resp_q all go to 0.
  - Round-robin pointer goes to 0; state goes to IDLE; the response latency pipe is cleared.
  - Any in-flight request or response is dropped, with no response issued.
- FSM states: IDLE and ISSUE.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching from ptr upward, wrapping at NUM_REQ-1 to 0.
  - req_ready[g] is asserted combinationally in the same cycle.
  - The issue buffer captures we/addr/data/id from requester g; next state is ISSUE.
- ISSUE:
  - ram_valid = 1; ram_we/addr/data come from the issue buffer and stay stable until the handshake.
  - On ram_ready = 1 (handshake), ptr becomes (g+1) mod NUM_REQ, and {id, we} is pushed into the latency pipe.
  - In the same handshake cycle the arbiter re-arbitrates using the updated ptr. If any req_valid bit is set, the new request is accepted (req_ready pulse) and the buffer is reloaded; state stays ISSUE. Otherwise state goes to IDLE.
  - Sustained throughput is therefore one transaction per cycle while ram_ready stays high.
- No acceptance while stalled: while in ISSUE with ram_ready = 0, req_ready is all zero.
- Latency: first request to RAM is one cycle after acceptance (ram_valid registered).
- Response timing: resp_valid is asserted exactly RD_LATENCY cycles after a handshake.
  - For reads, resp_q = ram_q sampled in that cycle.
  - For writes, resp_q = 0 and resp_we = 1.
  - Responses are never backpressured and come back in issue order.
- Fairness: a requester holding req_valid high is granted within NUM_REQ grants.
- Protocol rules:
  - req_valid may drop without acceptance; the arbiter never assumes persistence.
  - Bits in req_valid for an already-granted requester are treated as a new request.
- Simultaneous events:
  - Handshake plus new request in the same cycle: both are handled as above.
  - rst together with ram_ready: reset wins; the pipe is not pushed.
- Width rules: ptr and id are $clog2(NUM_REQ) bits; for non-power-of-two NUM_REQ, the wrap uses explicit compare, not overflow.

Test Plan:
- Reset mid-operation: requester 1 read addr 0x10 accepted, rst asserted the next cycle -> ram_valid = 0 the following cycle; no resp_valid ever for that request; ptr = 0 afterwards.
- Single write then read, requester 2: write 0x3C->0xA5, then read 0x3C, ram_ready tied 1 -> write ack (resp_id = 2, resp_we = 1, resp_q = 0) one cycle after handshake; read response resp_q = 0xA5, resp_id = 2.
- All four requesters valid continuously, ram_ready = 1 -> grant order 0,1,2,3,0,..., one handshake per cycle, 8 responses in the same id order.
- ram_ready held 0 for 5 cycles during ISSUE -> ram_addr/data/we stable, req_ready = 0 throughout; handshake on cycle 6; next grant the same cycle.
- Requester 3 only, ptr = 0 -> granted; next simultaneous requests from 0 and 3 -> 0 granted first (ptr = 0 after wrap from 3).
- RD_LATENCY = 3 build: three back-to-back reads of preloaded 0x01/0x02/0x03 -> resp_valid on cycles h+3, h+4, h+5 with matching q and ids.
